// File: rtl/i2c_apb_fifo.sv
// First-word-fall-through FIFO between the APB slave and the I2C core.
// One instance is used on the TX path and one on the RX path. EMPTY drives the TX_EMPTY/RX_EMPTY interrupts.
module i2c_apb_fifo #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              WR_EN,
    input  logic [DWIDTH-1:0] DATA_IN,
    input  logic              RD_EN,
    output logic [DWIDTH-1:0] DATA_OUT,
    output logic              FULL,
    output logic              EMPTY,
    output logic [AWIDTH:0]   COUNT,
    output logic              OVERFLOW,
    output logic              UNDERFLOW
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wp, rp;
    logic [AWIDTH:0]   cnt;
    logic              full, empty, push, pop;

    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);
    // A push into a full FIFO is allowed only when a pop frees a slot on the same edge.
    assign push  = WR_EN && (!full || RD_EN);
    assign pop   = RD_EN && !empty;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (push) wp <= wp + AWIDTH'(1);
            if (pop)  rp <= rp + AWIDTH'(1);
            if (push && !pop)      cnt <= cnt + (AWIDTH+1)'(1);
            else if (pop && !push) cnt <= cnt - (AWIDTH+1)'(1);
            OVERFLOW  <= WR_EN && full && !RD_EN;
            UNDERFLOW <= RD_EN && empty;
        end
    end

    // The storage array has no reset. Its contents are masked while the FIFO is empty.
    always_ff @(posedge PCLK) begin
        if (!PRESET && push) mem[wp] <= DATA_IN;
    end

    assign DATA_OUT = empty ? '0 : mem[rp];
    assign FULL     = full;
    assign EMPTY    = empty;
    assign COUNT    = cnt;
endmodule

// File: tb/tb_i2c_apb_fifo.sv
// Directed bench for i2c_apb_fifo. Each operation is driven on the falling edge and checked 1ns after the rising edge.
module tb_i2c_apb_fifo;
    logic        PCLK = 1'b0;
    logic        PRESET = 1'b0;
    logic        WR_EN = 1'b0;
    logic        RD_EN = 1'b0;
    logic [31:0] DATA_IN = '0;
    logic [31:0] DATA_OUT;
    logic        FULL, EMPTY, OVERFLOW, UNDERFLOW;
    logic [4:0]  COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    i2c_apb_fifo #(.DWIDTH(32), .AWIDTH(4)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .WR_EN(WR_EN), .DATA_IN(DATA_IN),
        .RD_EN(RD_EN), .DATA_OUT(DATA_OUT), .FULL(FULL), .EMPTY(EMPTY),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given request levels. Inputs return to idle right after the edge.
    task automatic cyc(input logic rst, input logic wr, input logic rd, input logic [31:0] d);
        @(negedge PCLK);
        PRESET = rst; WR_EN = wr; RD_EN = rd; DATA_IN = d;
        @(posedge PCLK);
        #1;
        PRESET = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; DATA_IN = '0;
    endtask

    task automatic chk_idle_empty(input string tag);
        chk({tag, ".empty"}, 64'(EMPTY), 64'd1);
        chk({tag, ".full"},  64'(FULL),  64'd0);
        chk({tag, ".count"}, 64'(COUNT), 64'd0);
        chk({tag, ".dout"},  64'(DATA_OUT), 64'd0);
    endtask

    initial begin
        // 1: reset state, then a single push and pop
        cyc(1, 0, 0, 0);
        chk_idle_empty("rst");
        chk("rst.ovf", 64'(OVERFLOW), 64'd0);
        chk("rst.udf", 64'(UNDERFLOW), 64'd0);
        cyc(0, 1, 0, 32'hA5A5_0001);
        chk("t1.empty", 64'(EMPTY), 64'd0);
        chk("t1.count", 64'(COUNT), 64'd1);
        chk("t1.dout",  64'(DATA_OUT), 64'hA5A5_0001);
        cyc(0, 0, 1, 0);
        chk_idle_empty("t1.pop");

        // 2: fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 32'h100 + i);
        chk("t2.full",  64'(FULL), 64'd1);
        chk("t2.count", 64'(COUNT), 64'd16);
        cyc(0, 1, 0, 32'hDEAD);
        chk("t2.ovf",   64'(OVERFLOW), 64'd1);
        chk("t2.count_ovf", 64'(COUNT), 64'd16);
        chk("t2.head",  64'(DATA_OUT), 64'h100);
        cyc(0, 0, 0, 0);
        chk("t2.ovf_clr", 64'(OVERFLOW), 64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2.pop%0d", i), 64'(DATA_OUT), 64'h100 + 64'(i));
            cyc(0, 0, 1, 0);
        end
        chk_idle_empty("t2.drained");

        // 3: underflow pulses, then normal use
        cyc(0, 0, 1, 0);
        chk("t3.udf",   64'(UNDERFLOW), 64'd1);
        chk("t3.count", 64'(COUNT), 64'd0);
        cyc(0, 0, 1, 0);
        chk("t3.udf2",  64'(UNDERFLOW), 64'd1);
        cyc(0, 0, 0, 0);
        chk("t3.udf_clr", 64'(UNDERFLOW), 64'd0);
        cyc(0, 1, 0, 32'h55);
        chk("t3.dout",  64'(DATA_OUT), 64'h55);
        chk("t3.count1", 64'(COUNT), 64'd1);
        cyc(0, 0, 1, 0);
        chk_idle_empty("t3.pop");
        chk("t3.no_udf", 64'(UNDERFLOW), 64'd0);

        // 4: simultaneous push/pop at count 5, 16 and 0
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 32'h300 + i);
        cyc(0, 1, 1, 32'h305);
        chk("t4.c5.count", 64'(COUNT), 64'd5);
        chk("t4.c5.head",  64'(DATA_OUT), 64'h301);
        for (int i = 6; i < 17; i++) cyc(0, 1, 0, 32'h300 + i);
        chk("t4.c16.full", 64'(FULL), 64'd1);
        cyc(0, 1, 1, 32'h311);
        chk("t4.c16.count", 64'(COUNT), 64'd16);
        chk("t4.c16.ovf",   64'(OVERFLOW), 64'd0);
        chk("t4.c16.head",  64'(DATA_OUT), 64'h302);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t4.drain%0d", i), 64'(DATA_OUT), 64'h302 + 64'(i));
            cyc(0, 0, 1, 0);
        end
        chk_idle_empty("t4.drained");
        cyc(0, 1, 1, 32'h400);
        chk("t4.c0.count", 64'(COUNT), 64'd1);
        chk("t4.c0.udf",   64'(UNDERFLOW), 64'd1);
        chk("t4.c0.dout",  64'(DATA_OUT), 64'h400);
        cyc(0, 0, 1, 0);
        chk_idle_empty("t4.c0.pop");

        // 5: pointer wrap-around
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 32'h50 + i);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("t5.pre%0d", i), 64'(DATA_OUT), 64'h50 + 64'(i));
            cyc(0, 0, 1, 0);
        end
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 32'h200 + i);
        chk("t5.count", 64'(COUNT), 64'd12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t5.wrap%0d", i), 64'(DATA_OUT), 64'h200 + 64'(i));
            cyc(0, 0, 1, 0);
        end
        chk_idle_empty("t5.drained");

        // 6: reset mid-stream with a push on the reset edge
        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 32'h600 + i);
        chk("t6.count7", 64'(COUNT), 64'd7);
        cyc(1, 1, 0, 32'h777);
        chk_idle_empty("t6.rst");
        chk("t6.ovf", 64'(OVERFLOW), 64'd0);
        chk("t6.udf", 64'(UNDERFLOW), 64'd0);
        cyc(0, 1, 0, 32'h999);
        chk("t6.dout",  64'(DATA_OUT), 64'h999);
        chk("t6.count", 64'(COUNT), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_apb_fifo.md
Name: i2c_apb_fifo

Overview:
- Synchronous first-word-fall-through FIFO. It buffers 32-bit words between the APB slave interface and the I2C core.
- One instance sits on the TX path. The APB write strobe and write data push into it; the I2C core pops from it.
- A second instance sits on the RX path. The I2C core pushes into it; the APB read strobe pops from it, and its head word drives the APB read data.
- Its empty flag is the source of the TX_EMPTY / RX_EMPTY interrupts.

Parameters:
- DWIDTH, 32, data word width in bits.
- AWIDTH, 4, address width; depth = 2**AWIDTH = 16 entries.

Ports:
- PCLK  input  1  clock; all logic on rising edge.
- PRESET  input  1  synchronous reset, active-high.
- WR_EN  input  1  push request; DATA_IN is written on the same edge.
- DATA_IN  input  DWIDTH  push data.
- RD_EN  input  1  pop request; removes the current head word.
- DATA_OUT  output  DWIDTH  head word (first-word-fall-through); 0 when EMPTY.
- FULL  output  1  high when COUNT == 2**AWIDTH.
- EMPTY  output  1  high when COUNT == 0.
- COUNT  output  AWIDTH+1  number of stored words, 0..2**AWIDTH.
- OVERFLOW  output  1  one-cycle registered pulse: push attempted while full and not simultaneously popped.
- UNDERFLOW  output  1  one-cycle registered pulse: pop attempted while empty.

Behaviour:
- Storage: 2**AWIDTH x DWIDTH register array; write pointer wp and read pointer rp, each AWIDTH bits; occupancy counter cnt, AWIDTH+1 bits.
- Reset (PRESET=1 at a rising edge):
  - wp=0, rp=0, cnt=0, OVERFLOW=0, UNDERFLOW=0.
  - Array contents are not cleared.
  - Outputs after the reset edge: EMPTY=1, FULL=0, COUNT=0, DATA_OUT=0.
  - Reset has priority over WR_EN/RD_EN on the same edge; a push or pop in that cycle is discarded.
- Push accepted when WR_EN=1 and (cnt < depth, or RD_EN=1 with cnt=depth). Effect: mem[wp] <= DATA_IN; wp <= wp+1, wrapping modulo depth.
- Pop accepted when RD_EN=1 and cnt > 0. Effect: rp <= rp+1, wrapping modulo depth.
- Counter update:
  - cnt+1 on push only.
  - cnt-1 on pop only.
  - unchanged when both are accepted or neither is.
- Simultaneous WR_EN and RD_EN:
  - cnt in 1..depth-1: both accepted, cnt unchanged.
  - cnt = depth (full): both accepted, cnt stays at depth, no OVERFLOW.
  - cnt = 0 (empty): push accepted, pop rejected. Next cycle: cnt=1, UNDERFLOW=1. There is no bypass, so the word pushed is not popped in the same cycle.
- Rejected requests:
  - Push while full without pop: data dropped, pointers unchanged, OVERFLOW=1 for exactly the next cycle.
  - Pop while empty: pointers unchanged, UNDERFLOW=1 for exactly the next cycle.
  - Back-to-back rejected requests give a pulse in each following cycle.
- Outputs:
  - DATA_OUT = EMPTY ? 0 : mem[rp]. Combinational from registers, no read latency. The pushed word is visible the cycle after the push edge.
  - FULL, EMPTY, COUNT are decoded combinationally from cnt. They update the cycle after the causing edge.
- Ordering: strict FIFO order across pointer wrap-around; no words lost or duplicated at the wp/rp wrap from 15 to 0.
- Levels: WR_EN and RD_EN are level-sampled. Each high cycle is one request. The upstream APB stage asserts them for exactly one access-phase cycle per transfer.
- No X on any output after the first reset edge.

Test Plan:
1. Reset, then push 0xA5A5_0001 in one cycle -> next cycle EMPTY=0, COUNT=1, DATA_OUT=0xA5A5_0001. Pop -> EMPTY=1, COUNT=0, DATA_OUT=0.
2. Push 16 words 0x100..0x10F -> FULL=1, COUNT=16. 17th push of 0xDEAD -> OVERFLOW pulse for 1 cycle, COUNT=16. Pop 16 -> 0x100..0x10F in order, 0xDEAD never appears.
3. Pop on empty FIFO -> UNDERFLOW=1 for one cycle, COUNT=0, pointers unchanged. A subsequent push/pop of 0x55 works normally.
4. Simultaneous WR_EN/RD_EN:
   - at COUNT=5: COUNT stays 5 and head advances.
   - at COUNT=16: COUNT stays 16, no OVERFLOW.
   - at COUNT=0: COUNT becomes 1 and UNDERFLOW pulses.
5. Wrap-around: push 10, pop 10, then push 12 words 0x200..0x20B, so wp wraps -> pops return 0x200..0x20B in order.
6. Reset mid-stream with COUNT=7 and WR_EN=1 on the reset edge -> next cycle COUNT=0, EMPTY=1, DATA_OUT=0, OVERFLOW=UNDERFLOW=0. The first post-reset push is read back correctly.
